// File: rtl/matrix_fill_arbiter.sv
// matrix_fill_arbiter
// Shares the single host port of the LED matrix frame memory (512 x 24-bit
// RGB) between CPU pass-through accesses and a fill engine that writes a
// constant colour to a run of consecutive addresses. The CPU has priority.
// A starvation counter forces one engine grant after STARVE_LIMIT denials.
//
// Ports:
//   csi_clk, rsi_reset_n   clock, asynchronous active-low reset
//   avs_s0_*               CPU pass-through slave (9-bit word address,
//                          24-bit data, waitrequest)
//   avs_s1_*               CSR slave: 0 COLOR, 1 START, 2 COUNT, 3 CTRL
//                          (zero wait, combinational readdata)
//   avm_m0_*               frame memory host port (readdata one cycle late)
//   irq                    level interrupt, done & irq_en
module matrix_fill_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        csi_clk,
  input  logic        rsi_reset_n,
  input  logic [8:0]  avs_s0_address,
  input  logic [23:0] avs_s0_writedata,
  input  logic [3:0]  avs_s0_byteenable,
  input  logic        avs_s0_write,
  input  logic        avs_s0_read,
  output logic [23:0] avs_s0_readdata,
  output logic        avs_s0_waitrequest,
  input  logic [1:0]  avs_s1_address,
  input  logic [31:0] avs_s1_writedata,
  input  logic        avs_s1_write,
  input  logic        avs_s1_read,
  output logic [31:0] avs_s1_readdata,
  output logic [8:0]  avm_m0_address,
  output logic [23:0] avm_m0_writedata,
  output logic [3:0]  avm_m0_byteenable,
  output logic        avm_m0_write,
  input  logic [23:0] avm_m0_readdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    ENG_IDLE   = 2'd0,
    ENG_RUN    = 2'd1,
    ENG_FINISH = 2'd2
  } eng_state_t;

  typedef enum logic {
    PORT_FREE   = 1'b0,
    PORT_CPU_RD = 1'b1
  } port_state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  // CSR shadow registers
  logic [23:0] color_r;
  logic [8:0]  start_r;
  logic [9:0]  count_r;
  logic        irq_en_r;
  logic        done_r;

  // Working copy of the fill in progress
  logic [23:0] work_color_r;
  logic [8:0]  work_addr_r;
  logic [9:0]  remaining_r;
  logic [3:0]  starve_r;

  eng_state_t  eng_state_r, eng_state_nxt_s;
  port_state_t port_state_r, port_state_nxt_s;

  logic cpu_req_s, eng_run_s, grant_eng_s, grant_cpu_s;
  logic ctrl_wr_s, go_s, busy_s;
  logic unused_s;

  assign unused_s  = ^avs_s1_writedata[31:24];
  assign cpu_req_s = avs_s0_read | avs_s0_write;
  assign eng_run_s = (eng_state_r == ENG_RUN);
  assign busy_s    = eng_run_s;
  assign ctrl_wr_s = avs_s1_write && (avs_s1_address == 2'd3);
  assign go_s      = ctrl_wr_s && avs_s1_writedata[0];
  assign irq       = done_r & irq_en_r;

  // Port arbitration and combinational drive of the memory/CPU signals
  always_comb begin
    grant_eng_s        = 1'b0;
    grant_cpu_s        = 1'b0;
    port_state_nxt_s   = port_state_r;
    avm_m0_address     = 9'd0;
    avm_m0_writedata   = 24'd0;
    avm_m0_byteenable  = 4'd0;
    avm_m0_write       = 1'b0;
    avs_s0_waitrequest = 1'b0;
    avs_s0_readdata    = 24'd0;
    case (port_state_r)
      PORT_FREE: begin
        // >= rather than == so a count that overshoots during CPU_RD still forces
        if (eng_run_s && (starve_r >= STARVE_MAX)) begin
          grant_eng_s = 1'b1;
        end else if (cpu_req_s) begin
          grant_cpu_s = 1'b1;
        end else begin
          grant_eng_s = eng_run_s;
        end
        if (grant_eng_s) begin
          avm_m0_address    = work_addr_r;
          avm_m0_writedata  = work_color_r;
          avm_m0_byteenable = 4'b0111;
          avm_m0_write      = 1'b1;
        end else if (grant_cpu_s) begin
          avm_m0_address    = avs_s0_address;
          avm_m0_writedata  = avs_s0_writedata;
          avm_m0_byteenable = avs_s0_byteenable;
          avm_m0_write      = avs_s0_write;
        end else begin
          avm_m0_write      = 1'b0;
        end
        // Only a granted write completes in the issue cycle
        avs_s0_waitrequest = cpu_req_s & ~(grant_cpu_s & avs_s0_write);
        if (grant_cpu_s && avs_s0_read) begin
          port_state_nxt_s = PORT_CPU_RD;
        end else begin
          port_state_nxt_s = PORT_FREE;
        end
      end
      PORT_CPU_RD: begin
        avs_s0_readdata    = avm_m0_readdata;
        avs_s0_waitrequest = 1'b0;
        port_state_nxt_s   = PORT_FREE;
      end
      default: begin
        port_state_nxt_s = PORT_FREE;
      end
    endcase
  end

  // Fill engine next-state logic
  always_comb begin
    eng_state_nxt_s = eng_state_r;
    case (eng_state_r)
      ENG_IDLE: begin
        if (go_s) begin
          eng_state_nxt_s = (count_r != 10'd0) ? ENG_RUN : ENG_FINISH;
        end else begin
          eng_state_nxt_s = ENG_IDLE;
        end
      end
      ENG_RUN: begin
        if (grant_eng_s && (remaining_r == 10'd1)) begin
          eng_state_nxt_s = ENG_FINISH;
        end else begin
          eng_state_nxt_s = ENG_RUN;
        end
      end
      ENG_FINISH: eng_state_nxt_s = ENG_IDLE;
      default:    eng_state_nxt_s = ENG_IDLE;
    endcase
  end

  // State registers for engine and port
  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      eng_state_r  <= ENG_IDLE;
      port_state_r <= PORT_FREE;
    end else begin
      eng_state_r  <= eng_state_nxt_s;
      port_state_r <= port_state_nxt_s;
    end
  end

  // Working registers: captured on GO, advanced on each engine grant
  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      work_color_r <= 24'd0;
      work_addr_r  <= 9'd0;
      remaining_r  <= 10'd0;
    end else if ((eng_state_r == ENG_IDLE) && go_s && (count_r != 10'd0)) begin
      work_color_r <= color_r;
      work_addr_r  <= start_r;
      remaining_r  <= count_r;
    end else if (grant_eng_s) begin
      work_addr_r  <= work_addr_r + 9'd1;
      remaining_r  <= remaining_r - 10'd1;
    end else begin
      work_addr_r  <= work_addr_r;
    end
  end

  // Starvation counter: counts denied RUN cycles, saturating
  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      starve_r <= 4'd0;
    end else if (!eng_run_s || grant_eng_s) begin
      starve_r <= 4'd0;
    end else if (starve_r != 4'hF) begin
      starve_r <= starve_r + 4'd1;
    end else begin
      starve_r <= starve_r;
    end
  end

  // CSR writes; FINISH beats a simultaneous DONE_CLR
  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      color_r  <= 24'd0;
      start_r  <= 9'd0;
      count_r  <= 10'd0;
      irq_en_r <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      if (avs_s1_write) begin
        case (avs_s1_address)
          2'd0:    color_r  <= avs_s1_writedata[23:0];
          2'd1:    start_r  <= avs_s1_writedata[8:0];
          2'd2:    count_r  <= avs_s1_writedata[9:0];
          2'd3:    irq_en_r <= avs_s1_writedata[1];
          default: color_r  <= color_r;
        endcase
      end
      if (eng_state_r == ENG_FINISH) begin
        done_r <= 1'b1;
      end else if (ctrl_wr_s && avs_s1_writedata[2]) begin
        done_r <= 1'b0;
      end else begin
        done_r <= done_r;
      end
    end
  end

  // CSR readback
  always_comb begin
    avs_s1_readdata = 32'd0;
    if (avs_s1_read) begin
      case (avs_s1_address)
        2'd0:    avs_s1_readdata = {8'd0, color_r};
        2'd1:    avs_s1_readdata = {23'd0, start_r};
        2'd2:    avs_s1_readdata = {22'd0, count_r};
        2'd3:    avs_s1_readdata = {29'd0, irq_en_r, done_r, busy_s};
        default: avs_s1_readdata = 32'd0;
      endcase
    end else begin
      avs_s1_readdata = 32'd0;
    end
  end

endmodule

// File: tb/tb_matrix_fill_arbiter.sv
// Directed bench for matrix_fill_arbiter with a behavioural frame memory.
module tb_matrix_fill_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [8:0]  s0_address;
  logic [23:0] s0_writedata;
  logic [3:0]  s0_byteenable;
  logic        s0_write, s0_read;
  logic [23:0] s0_readdata;
  logic        s0_waitrequest;
  logic [1:0]  s1_address;
  logic [31:0] s1_writedata;
  logic        s1_write, s1_read;
  logic [31:0] s1_readdata;
  logic [8:0]  m0_address;
  logic [23:0] m0_writedata;
  logic [3:0]  m0_byteenable;
  logic        m0_write;
  logic [23:0] m0_readdata;
  logic        irq;

  int n_assert = 0;
  int n_fail   = 0;
  logic [23:0] mem [0:511];

  always #5 clk = ~clk;

  matrix_fill_arbiter #(.STARVE_LIMIT(4)) dut (
    .csi_clk            (clk),
    .rsi_reset_n        (rst_n),
    .avs_s0_address     (s0_address),
    .avs_s0_writedata   (s0_writedata),
    .avs_s0_byteenable  (s0_byteenable),
    .avs_s0_write       (s0_write),
    .avs_s0_read        (s0_read),
    .avs_s0_readdata    (s0_readdata),
    .avs_s0_waitrequest (s0_waitrequest),
    .avs_s1_address     (s1_address),
    .avs_s1_writedata   (s1_writedata),
    .avs_s1_write       (s1_write),
    .avs_s1_read        (s1_read),
    .avs_s1_readdata    (s1_readdata),
    .avm_m0_address     (m0_address),
    .avm_m0_writedata   (m0_writedata),
    .avm_m0_byteenable  (m0_byteenable),
    .avm_m0_write       (m0_write),
    .avm_m0_readdata    (m0_readdata),
    .irq                (irq)
  );

  // Frame memory: byte-enabled write, registered read
  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 24'd0;
    m0_readdata = 24'd0;
  end
  always @(posedge clk) begin
    if (m0_write) begin
      if (m0_byteenable[0]) mem[m0_address][7:0]   <= m0_writedata[7:0];
      if (m0_byteenable[1]) mem[m0_address][15:8]  <= m0_writedata[15:8];
      if (m0_byteenable[2]) mem[m0_address][23:16] <= m0_writedata[23:16];
    end
    m0_readdata <= mem[m0_address];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
    s1_address = a; s1_writedata = d; s1_write = 1'b1;
    next_cycle();
    s1_write = 1'b0;
  endtask

  task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
    s1_address = a; s1_read = 1'b1;
    @(negedge clk);
    d = s1_readdata;
    next_cycle();
    s1_read = 1'b0;
  endtask

  // Engine write at the current negedge: port fields then data
  task automatic chk_eng(input string tag, input logic [8:0] ea, input logic [23:0] ec,
                         input logic wr_wait);
    chk({tag, "_port"}, {m0_write, m0_byteenable, m0_address, s0_waitrequest},
        {1'b1, 4'b0111, ea, wr_wait});
    chk({tag, "_data"}, m0_writedata, ec);
  endtask

  logic [31:0] rd;
  logic [8:0]  exp_a [4];
  int          j;

  initial begin
    rst_n = 1'b0;
    s0_address = 9'd0; s0_writedata = 24'd0; s0_byteenable = 4'd0;
    s0_write = 1'b0; s0_read = 1'b0;
    s1_address = 2'd0; s1_writedata = 32'd0; s1_write = 1'b0; s1_read = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    next_cycle();

    // Reset state
    @(negedge clk);
    chk("rst_port", {m0_write, m0_address, m0_byteenable}, 32'd0);
    chk("rst_s0", {s0_waitrequest, s0_readdata, irq}, 32'd0);
    next_cycle();
    for (int a = 0; a < 4; a++) begin
      csr_read(2'(a), rd);
      chk("rst_csr", rd, 32'd0);
    end

    // Full-frame fill, no CPU traffic
    csr_write(2'd0, 32'h0012_3456);
    csr_write(2'd1, 32'd0);
    csr_write(2'd2, 32'd512);
    csr_write(2'd3, 32'h1);
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      chk_eng("fill512", 9'(i), 24'h123456, 1'b0);
      next_cycle();
    end
    @(negedge clk);
    chk("fill512_finish_nowr", {31'd0, m0_write}, 32'd0);
    next_cycle();
    csr_read(2'd3, rd);
    chk("fill512_ctrl", rd, 32'h2);
    chk("fill512_irq", {31'd0, irq}, 32'd0);
    chk("fill512_mem", {8'd0, mem[300]}, 32'h0012_3456);

    // Wrapping fill with interrupt
    exp_a[0] = 9'd510; exp_a[1] = 9'd511; exp_a[2] = 9'd0; exp_a[3] = 9'd1;
    csr_write(2'd0, 32'h00AA_0055);
    csr_write(2'd1, 32'd510);
    csr_write(2'd2, 32'd4);
    csr_write(2'd3, 32'h6);
    chk("wrap_irq_clr", {31'd0, irq}, 32'd0);
    csr_write(2'd3, 32'h3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_eng("wrap", exp_a[i], 24'hAA0055, 1'b0);
      next_cycle();
    end
    @(negedge clk);
    chk("wrap_finish_irq", {30'd0, m0_write, irq}, 32'd0);
    next_cycle();
    csr_read(2'd3, rd);
    chk("wrap_ctrl", rd, 32'h6);
    chk("wrap_irq_high", {31'd0, irq}, 32'd1);
    csr_write(2'd3, 32'h6);
    @(negedge clk);
    chk("wrap_irq_dropped", {31'd0, irq}, 32'd0);
    next_cycle();

    // Fill under back-to-back CPU writes: every 5th cycle is forced
    csr_write(2'd0, 32'h00A5_A5A5);
    csr_write(2'd1, 32'd32);
    csr_write(2'd2, 32'd16);
    csr_write(2'd3, 32'h3);
    j = 0;
    for (int k = 1; k <= 80; k++) begin
      s0_write = 1'b1; s0_address = 9'(100 + j);
      s0_writedata = 24'h001000 + 24'(j); s0_byteenable = 4'hF;
      @(negedge clk);
      if (k % 5 == 0) begin
        chk_eng("contend_eng", 9'(32 + k / 5 - 1), 24'hA5A5A5, 1'b1);
      end else begin
        chk("contend_cpu", {m0_write, m0_byteenable, m0_address, s0_waitrequest},
            {1'b1, 4'hF, 9'(100 + j), 1'b0});
        j++;
      end
      next_cycle();
    end
    s0_write = 1'b0;
    @(negedge clk);
    chk("contend_finish_nowr", {31'd0, m0_write}, 32'd0);
    next_cycle();
    csr_read(2'd3, rd);
    chk("contend_ctrl", rd, 32'h6);
    chk("contend_cpu_count", 32'(j), 32'd64);
    for (int e = 0; e < 16; e++) chk("contend_mem_eng", {8'd0, mem[32 + e]}, 32'h00A5_A5A5);
    for (int c = 0; c < 64; c++) chk("contend_mem_cpu", {8'd0, mem[100 + c]}, 32'h1000 + 32'(c));

    // CPU write then read of address 7, with a fill pending
    s0_write = 1'b1; s0_address = 9'd7; s0_writedata = 24'h00ABCD; s0_byteenable = 4'hF;
    @(negedge clk);
    chk("cpuwr_nowait", {31'd0, s0_waitrequest}, 32'd0);
    next_cycle();
    s0_write = 1'b0;
    csr_write(2'd1, 32'd200);
    csr_write(2'd2, 32'd3);
    csr_write(2'd3, 32'h6);
    csr_write(2'd3, 32'h3);
    s0_read = 1'b1; s0_address = 9'd7;
    @(negedge clk);
    chk("cpurd_c0", {m0_write, m0_address, s0_waitrequest}, {1'b0, 9'd7, 1'b1});
    next_cycle();
    @(negedge clk);
    chk("cpurd_c1", {m0_write, s0_waitrequest}, 32'd0);
    chk("cpurd_data", {8'd0, s0_readdata}, 32'h0000_ABCD);
    next_cycle();
    s0_read = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_eng("after_rd", 9'(200 + i), 24'hA5A5A5, 1'b0);
      next_cycle();
    end
    next_cycle();

    // GO with COUNT = 0
    csr_write(2'd2, 32'd0);
    csr_write(2'd3, 32'h6);
    csr_write(2'd3, 32'h3);
    s1_address = 2'd3; s1_read = 1'b1;
    @(negedge clk);
    chk("cnt0_nowr", {31'd0, m0_write}, 32'd0);
    chk("cnt0_ctrl_t1", s1_readdata, 32'h4);
    next_cycle();
    s1_read = 1'b0;
    csr_read(2'd3, rd);
    chk("cnt0_ctrl_t2", rd, 32'h6);

    // Second GO and CSR rewrites during a fill
    csr_write(2'd3, 32'h6);
    csr_write(2'd0, 32'h000F_0F0F);
    csr_write(2'd1, 32'd300);
    csr_write(2'd2, 32'd6);
    csr_write(2'd3, 32'h3);
    for (int i = 0; i < 6; i++) begin
      case (i)
        1: begin s1_address = 2'd0; s1_writedata = 32'h00FF_FFFF; s1_write = 1'b1; end
        2: begin s1_address = 2'd2; s1_writedata = 32'd2;         s1_write = 1'b1; end
        3: begin s1_address = 2'd3; s1_writedata = 32'h3;         s1_write = 1'b1; end
        default: s1_write = 1'b0;
      endcase
      @(negedge clk);
      chk_eng("midfill", 9'(300 + i), 24'h0F0F0F, 1'b0);
      next_cycle();
    end
    s1_write = 1'b0;
    @(negedge clk);
    chk("midfill_finish", {31'd0, m0_write}, 32'd0);
    next_cycle();
    @(negedge clk);
    chk("midfill_idle", {31'd0, m0_write}, 32'd0);
    next_cycle();
    csr_read(2'd3, rd);
    chk("midfill_ctrl", rd, 32'h6);
    csr_read(2'd0, rd);
    chk("midfill_color_shadow", rd, 32'h00FF_FFFF);
    csr_read(2'd2, rd);
    chk("midfill_count_shadow", rd, 32'd2);

    // Reset pulsed mid-fill
    csr_write(2'd0, 32'h0077_7777);
    csr_write(2'd1, 32'd400);
    csr_write(2'd2, 32'd20);
    csr_write(2'd3, 32'h3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_eng("prerst", 9'(400 + i), 24'h777777, 1'b0);
      next_cycle();
    end
    rst_n = 1'b0;
    #1;
    chk("rst_mid_nowr", {31'd0, m0_write}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("postrst_nowr", {30'd0, m0_write, irq}, 32'd0);
      next_cycle();
    end
    for (int a = 0; a < 4; a++) begin
      csr_read(2'(a), rd);
      chk("postrst_csr", rd, 32'd0);
    end
    chk("postrst_mem402", {8'd0, mem[402]}, 32'h0077_7777);
    chk("postrst_mem403", {8'd0, mem[403]}, 32'h0012_3456);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
